// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared RV32I constants, MEM FSM states and access-size helper
package rv_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } mem_size_e;

  // Undefined funct3 encodings fall back to a full-word access.
  function automatic mem_size_e size_of(input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_BU: return SZ_BYTE;
      F3_H, F3_HU: return SZ_HALF;
      default:     return SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/memory_stage_if.sv
// rtl/memory_stage_if.sv - single-port data-memory request/ready bus
interface memory_stage_if #(
  parameter int XLEN = 32
);
  logic            req;
  logic            we;
  logic [XLEN-1:0] addr;
  logic [3:0]      be;
  logic [XLEN-1:0] wdata;
  logic [XLEN-1:0] rdata;
  logic            ready;

  modport master (
    output req, we, addr, be, wdata,
    input  rdata, ready
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output rdata, ready
  );
endinterface

// File: rtl/load_extend.sv
// rtl/load_extend.sv - byte/half lane select and sign/zero extension of load data
module load_extend
  import rv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      addr_lo,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed lane, then extend it according to funct3.
  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_B:    result = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_BU:   result = {{(XLEN-8){1'b0}}, byte_sel};
      F3_H:    result = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_HU:   result = {{(XLEN-16){1'b0}}, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - RV32I MEM stage: dmem request FSM, store lanes, load extend, MEM/WB register
module memory_stage
  import rv_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int MAX_WAIT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RegWriteM,
  input  logic                  MemWriteM,
  input  logic                  MemtoRegM,
  input  logic [2:0]            strCtrlM,
  input  logic [XLEN-1:0]       ALUoutM,
  input  logic [XLEN-1:0]       r2M,
  input  logic [4:0]            rdM,
  memory_stage_if.master        dmem,
  output logic                  stallM,
  output logic                  misalignM,
  output logic                  busErrM,
  output logic                  RegWriteW,
  output logic                  MemtoRegW,
  output logic [4:0]            rdW,
  output logic [XLEN-1:0]       ALUoutW,
  output logic [XLEN-1:0]       ReadDataW
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] LAST_WAIT = CW'(MAX_WAIT - 1);

  mem_state_e      state;
  logic [CW-1:0]   wait_cnt;

  mem_size_e       size;
  logic            memop;
  logic            misaligned;
  logic            issue;
  logic            in_wait;
  logic            abort;
  logic            complete;
  logic            load_w;
  logic            bubble_w;
  logic [XLEN-1:0] load_data;

  // Access decode and alignment check on the held M-stage operands.
  always_comb begin
    memop = MemWriteM | MemtoRegM;
    size  = size_of(strCtrlM);
    case (size)
      SZ_HALF: misaligned = ALUoutM[0];
      SZ_WORD: misaligned = (ALUoutM[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
  end

  // Request/stall outputs; gated by rst so they drop the moment reset asserts.
  always_comb begin
    issue      = rst && (state == IDLE) && memop && !misaligned;
    in_wait    = rst && (state == WAIT);
    dmem.req   = issue | in_wait;
    dmem.we    = dmem.req & MemWriteM;
    dmem.addr  = {ALUoutM[XLEN-1:2], 2'b00};
    abort      = in_wait && !dmem.ready && (wait_cnt == LAST_WAIT);
    complete   = dmem.req && dmem.ready;
    stallM     = dmem.req && !dmem.ready && !abort;
    misalignM  = rst && (state == IDLE) && memop && misaligned;
    busErrM    = abort;
    load_w     = complete || ((state == IDLE) && !memop);
    bubble_w   = stallM || misalignM || busErrM;
  end

  // Store lane replication and byte enables; enables stay clear on reads.
  always_comb begin
    case (size)
      SZ_BYTE: dmem.wdata = {4{r2M[7:0]}};
      SZ_HALF: dmem.wdata = {2{r2M[15:0]}};
      default: dmem.wdata = r2M;
    endcase
    if (dmem.we) begin
      case (size)
        SZ_BYTE: dmem.be = 4'b0001 << ALUoutM[1:0];
        SZ_HALF: dmem.be = 4'b0011 << {ALUoutM[1], 1'b0};
        default: dmem.be = 4'b1111;
      endcase
    end else begin
      dmem.be = 4'b0000;
    end
  end

  load_extend #(
    .XLEN (XLEN)
  ) u_load_extend (
    .rdata   (dmem.rdata),
    .addr_lo (ALUoutM[1:0]),
    .funct3  (strCtrlM),
    .result  (load_data)
  );

  // MEM FSM: leave IDLE only when the first request cycle is not accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (issue && !dmem.ready) begin
            state    <= WAIT;
            wait_cnt <= '0;
          end
        end
        WAIT: begin
          if (dmem.ready || abort) begin
            state    <= IDLE;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  // MEM/WB register: capture on completion or non-memory op, bubble otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWriteW <= 1'b0;
      MemtoRegW <= 1'b0;
      rdW       <= '0;
      ALUoutW   <= '0;
      ReadDataW <= '0;
    end else if (load_w) begin
      RegWriteW <= RegWriteM;
      MemtoRegW <= MemtoRegM;
      rdW       <= rdM;
      ALUoutW   <= ALUoutM;
      ReadDataW <= load_data;
    end else if (bubble_w) begin
      RegWriteW <= 1'b0;
      MemtoRegW <= 1'b0;
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// tb/tb_memory_stage.sv - randomized self-checking bench for memory_stage
module tb_memory_stage;

  localparam int MAX_WAIT = 16;
  localparam int NEVER    = 1000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        RegWriteM = 1'b0, MemWriteM = 1'b0, MemtoRegM = 1'b0;
  logic [2:0]  strCtrlM = 3'b000;
  logic [31:0] ALUoutM = '0, r2M = '0;
  logic [4:0]  rdM = '0;
  logic        stallM, misalignM, busErrM, RegWriteW, MemtoRegW;
  logic [4:0]  rdW;
  logic [31:0] ALUoutW, ReadDataW;

  memory_stage_if #(.XLEN(32)) dmem ();

  memory_stage #(.XLEN(32), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .MemtoRegM(MemtoRegM),
    .strCtrlM(strCtrlM), .ALUoutM(ALUoutM), .r2M(r2M), .rdM(rdM),
    .dmem(dmem),
    .stallM(stallM), .misalignM(misalignM), .busErrM(busErrM),
    .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW), .rdW(rdW),
    .ALUoutW(ALUoutW), .ReadDataW(ReadDataW)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;

  logic        exp_req, exp_we, exp_stall, exp_mis, exp_berr;
  logic [31:0] exp_addr, exp_wdata;
  logic [3:0]  exp_be;
  logic        m_rw = 0, m_mtr = 0;
  logic [4:0]  m_rd = 0;
  logic [31:0] m_alu = 0, m_rdata = 0;

  int          stall_seen, mis_seen, berr_seen;
  logic        last_we;
  logic [3:0]  last_be;
  logic [31:0] last_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int nbytes(input logic [2:0] f3);
    if (f3 == 3'b000 || f3 == 3'b100) return 1;
    if (f3 == 3'b001 || f3 == 3'b101) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] ext(input logic [31:0] d, input logic [1:0] off, input logic [2:0] f3);
    logic [31:0] sh;
    sh = d >> (8 * off);
    case (f3)
      3'b000: return (sh & 32'hFF) | (sh[7] ? 32'hFFFFFF00 : 32'h0);
      3'b100: return sh & 32'hFF;
      3'b001: return (sh & 32'hFFFF) | (sh[15] ? 32'hFFFF0000 : 32'h0);
      3'b101: return sh & 32'hFFFF;
      default: return d;
    endcase
  endfunction

  // Per-cycle comparison of the DUT against the model expectations.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("req", dmem.req, exp_req);
      chk("stall", stallM, exp_stall);
      chk("misalign", misalignM, exp_mis);
      chk("buserr", busErrM, exp_berr);
      if (exp_req) begin
        chk("we", dmem.we, exp_we);
        chk("addr", dmem.addr, exp_addr);
        chk("be", dmem.be, exp_be);
        if (exp_we) chk("wdata", dmem.wdata, exp_wdata);
      end
      chk("RegWriteW", RegWriteW, m_rw);
      chk("MemtoRegW", MemtoRegW, m_mtr);
      chk("rdW", rdW, m_rd);
      chk("ALUoutW", ALUoutW, m_alu);
      if (m_mtr) chk("ReadDataW", ReadDataW, m_rdata);
    end
  end

  // Present one M-stage op, answer after `delay` cycles, update the W model.
  task automatic do_op(input logic mw, input logic mr, input logic rw, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] r2, input logic [4:0] rd,
                       input int delay, input logic [31:0] rdv);
    int   sz;
    logic memop, mis, rdy, abort, done;
    MemWriteM = mw; MemtoRegM = mr; RegWriteM = rw; strCtrlM = f3;
    ALUoutM = a; r2M = r2; rdM = rd;
    memop = mw | mr;
    sz = nbytes(f3);
    mis = memop && ((sz == 2 && a[0]) || (sz == 4 && a[1:0] != 2'b00));
    stall_seen = 0; mis_seen = 0; berr_seen = 0;
    done = 1'b0;
    for (int k = 0; k < 100 && !done; k++) begin
      rdy = memop && !mis && (k == delay);
      abort = memop && !mis && !rdy && (k == MAX_WAIT);
      dmem.ready = rdy;
      dmem.rdata = rdy ? rdv : $urandom;
      exp_req   = memop && !mis;
      exp_we    = mw;
      exp_addr  = a & 32'hFFFFFFFC;
      exp_be    = !mw ? 4'b0000 : (sz == 1) ? (4'b0001 << a[1:0]) :
                  (sz == 2) ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
      exp_wdata = (sz == 1) ? r2[7:0] * 32'h01010101 :
                  (sz == 2) ? r2[15:0] * 32'h00010001 : r2;
      exp_stall = exp_req && !rdy && !abort;
      exp_mis   = mis;
      exp_berr  = abort;
      done = !exp_stall;
      @(negedge clk);
      stall_seen += int'(stallM);
      mis_seen   += int'(misalignM);
      berr_seen  += int'(busErrM);
      last_we = dmem.we; last_be = dmem.be; last_wdata = dmem.wdata;
      @(posedge clk); #1;
      if (done && (!memop || rdy)) begin
        m_rw = rw; m_mtr = mr; m_rd = rd; m_alu = a;
        if (mr) m_rdata = ext(rdv, a[1:0], f3);
      end else begin
        m_rw = 1'b0; m_mtr = 1'b0;
      end
    end
    dmem.ready = 1'b0;
    if (!done) chk("op_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    dmem.ready = 1'b0;
    dmem.rdata = '0;
    exp_req = 0; exp_we = 0; exp_stall = 0; exp_mis = 0; exp_berr = 0;
    exp_addr = 0; exp_wdata = 0; exp_be = 0;
    MemtoRegM = 1'b1; strCtrlM = 3'b010; ALUoutM = 32'h100;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", dmem.req, 1'b0);
    chk("rst_stall", stallM, 1'b0);
    chk("rst_regw", RegWriteW, 1'b0);
    chk("rst_aluw", ALUoutW, 32'h0);
    MemtoRegM = 1'b0; strCtrlM = 3'b000; ALUoutM = '0;
    @(posedge clk); #1;
    rst = 1'b1;
    chk_en = 1'b1;

    do_op(0, 1, 1, 3'b010, 32'h100, 0, 5'd1, 0, 32'hDEADBEEF);
    chk("lw_rd", ReadDataW, 32'hDEADBEEF);
    chk("lw_mtr", MemtoRegW, 1'b1);
    chk("lw_nostall", stall_seen, 0);
    do_op(0, 1, 1, 3'b000, 32'h103, 0, 5'd2, 0, 32'h80123456);
    chk("lb_rd", ReadDataW, 32'hFFFFFF80);
    do_op(0, 1, 1, 3'b100, 32'h103, 0, 5'd3, 0, 32'h80123456);
    chk("lbu_rd", ReadDataW, 32'h00000080);
    do_op(0, 1, 1, 3'b001, 32'h102, 0, 5'd4, 0, 32'h80123456);
    chk("lh_rd", ReadDataW, 32'hFFFF8012);
    do_op(1, 0, 0, 3'b000, 32'h201, 32'h000000AB, 5'd0, 0, 0);
    chk("sb_we", last_we, 1'b1);
    chk("sb_be", last_be, 4'b0010);
    chk("sb_wdata", last_wdata, 32'hABABABAB);
    do_op(1, 0, 0, 3'b001, 32'h202, 32'h00001234, 5'd0, 0, 0);
    chk("sh_be", last_be, 4'b1100);
    chk("sh_wdata", last_wdata, 32'h12341234);
    do_op(0, 1, 1, 3'b010, 32'h300, 0, 5'd5, 3, 32'hCAFEF00D);
    chk("lw3_stalls", stall_seen, 3);
    chk("lw3_rd", ReadDataW, 32'hCAFEF00D);
    do_op(0, 1, 1, 3'b010, 32'h102, 0, 5'd6, 0, 32'h11111111);
    chk("mis_pulse", mis_seen, 1);
    chk("mis_regw", RegWriteW, 1'b0);
    do_op(0, 1, 1, 3'b010, 32'h400, 0, 5'd7, NEVER, 0);
    chk("berr_pulse", berr_seen, 1);
    chk("berr_stalls", stall_seen, MAX_WAIT);
    chk("berr_regw", RegWriteW, 1'b0);
    do_op(0, 0, 1, 3'b000, 32'h12345678, 0, 5'd8, 0, 0);
    chk("alu_pass", ALUoutW, 32'h12345678);

    for (int i = 0; i < 200; i++) begin
      int kind, dly;
      logic [2:0] f3;
      logic [31:0] a;
      kind = $urandom_range(0, 2);
      dly  = ($urandom_range(0, 15) == 0) ? NEVER : $urandom_range(0, 4);
      a    = $urandom & 32'h0000FFFF;
      if (kind == 2) f3 = 3'($urandom_range(0, 2));
      else           f3 = 3'($urandom_range(0, 7));
      do_op(kind == 2, kind == 1, kind != 2, f3, a, $urandom, 5'($urandom), dly, $urandom);
    end

    chk_en = 1'b0;
    MemWriteM = 1'b0; MemtoRegM = 1'b1; RegWriteM = 1'b1; strCtrlM = 3'b010;
    ALUoutM = 32'h500; dmem.ready = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("rstw_req", dmem.req, 1'b0);
    chk("rstw_stall", stallM, 1'b0);
    chk("rstw_regw", RegWriteW, 1'b0);
    chk("rstw_rdw", rdW, 5'd0);
    chk("rstw_aluw", ALUoutW, 32'h0);
    MemtoRegM = 1'b0; RegWriteM = 1'b0; ALUoutM = '0; rdM = '0; r2M = '0;
    @(posedge clk); #1;
    m_rw = 0; m_mtr = 0; m_rd = 0; m_alu = 0; m_rdata = 0;
    rst = 1'b1;
    chk_en = 1'b1;
    do_op(0, 1, 1, 3'b010, 32'h104, 0, 5'd9, 1, 32'h0BADC0DE);
    chk("post_rst_rd", ReadDataW, 32'h0BADC0DE);
    chk("post_rst_stalls", stall_seen, 1);
    do_op(0, 0, 0, 3'b000, 32'h0, 0, 5'd0, 0, 0);
    chk_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
